// File: rtl/lif_array_pkg.sv
// Shared constants, spike-mode enum and saturating add for the LIF neuron array.
package lif_pkg;

    localparam int LIF_N           = 4;
    localparam int LIF_W           = 8;
    localparam int LIF_LEAK_SHIFT  = 2;
    localparam int LIF_REFRACT     = 3;
    localparam int LIF_THRESH_INIT = 200;

    typedef enum logic {
        LIF_MODE_RESET = 1'b0,
        LIF_MODE_SUB   = 1'b1
    } lif_mode_e;

    // a + b clamped to 2^w-1; w must be below 32
    function automatic logic [31:0] lif_sat_add(
        input logic [31:0] a,
        input logic [31:0] b,
        input int          w
    );
        logic [32:0] s;
        logic [32:0] lim;
        s   = {1'b0, a} + {1'b0, b};
        lim = (33'd1 << w) - 33'd1;
        return (s > lim) ? lim[31:0] : s[31:0];
    endfunction

endpackage

// File: rtl/lif_array_if.sv
// Stimulus/config/result bundle between current sources, the LIF array and spike routing.
interface lif_array_if #(
    parameter int N = 4,
    parameter int W = 8
);
    logic           step_en;
    logic [N*W-1:0] current;
    logic           cfg_we;
    logic [W-1:0]   cfg_thresh;
    logic           cfg_mode;
    logic [N-1:0]   spike;
    logic [N*W-1:0] state_out;

    modport master (
        output step_en, current, cfg_we, cfg_thresh, cfg_mode,
        input  spike, state_out
    );

    modport slave (
        input  step_en, current, cfg_we, cfg_thresh, cfg_mode,
        output spike, state_out
    );
endinterface

// File: rtl/lif_array_core.sv
// One leaky-integrate-and-fire neuron: membrane state, refractory counter, spike flag.
module lif_core
    import lif_pkg::*;
#(
    parameter int W          = LIF_W,
    parameter int LEAK_SHIFT = LIF_LEAK_SHIFT,
    parameter int REFRACT    = LIF_REFRACT
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         step_en_i,
    input  logic [W-1:0] current_i,
    input  logic [W-1:0] thresh_i,
    input  lif_mode_e    mode_i,
    output logic         spike_o,
    output logic [W-1:0] state_o
);
    localparam int CW = (REFRACT > 0) ? $clog2(REFRACT + 1) : 1;

    logic [W-1:0]  state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          spike_q, spike_d;
    logic [W-1:0]  leak;
    logic [W-1:0]  next;

    always_comb begin
        leak = '0;
        if (LEAK_SHIFT != 0) begin
            leak = state_q >> LEAK_SHIFT;
        end
        next = W'(lif_sat_add(32'(state_q - leak), 32'(current_i), W));

        state_d = state_q;
        cnt_d   = cnt_q;
        spike_d = 1'b0;
        if (step_en_i) begin
            if (cnt_q != '0) begin
                cnt_d = cnt_q - CW'(1);
            end else if (next >= thresh_i) begin
                spike_d = 1'b1;
                cnt_d   = CW'(REFRACT);
                state_d = (mode_i == LIF_MODE_SUB) ? next - thresh_i : '0;
            end else begin
                state_d = next;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= '0;
            cnt_q   <= '0;
            spike_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            spike_q <= spike_d;
        end
    end

    assign spike_o = spike_q;
    assign state_o = state_q;

endmodule

// File: rtl/lif_array.sv
// N independent LIF neurons sharing one runtime threshold/mode config register pair.
module lif_array
    import lif_pkg::*;
#(
    parameter int N           = LIF_N,
    parameter int W           = LIF_W,
    parameter int LEAK_SHIFT  = LIF_LEAK_SHIFT,
    parameter int REFRACT     = LIF_REFRACT,
    parameter int THRESH_INIT = LIF_THRESH_INIT
) (
    input logic        clk,
    input logic        reset_n,
    lif_array_if.slave bus
);
    logic [W-1:0] thresh_q, thresh_d;
    lif_mode_e    mode_q, mode_d;

    // Config lands after the edge, so a same-cycle step still sees the old values
    always_comb begin
        thresh_d = thresh_q;
        mode_d   = mode_q;
        if (bus.cfg_we) begin
            thresh_d = bus.cfg_thresh;
            mode_d   = lif_mode_e'(bus.cfg_mode);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            thresh_q <= W'(THRESH_INIT);
            mode_q   <= LIF_MODE_RESET;
        end else begin
            thresh_q <= thresh_d;
            mode_q   <= mode_d;
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_neuron
        lif_core #(
            .W          (W),
            .LEAK_SHIFT (LEAK_SHIFT),
            .REFRACT    (REFRACT)
        ) u_core (
            .clk       (clk),
            .reset_n   (reset_n),
            .step_en_i (bus.step_en),
            .current_i (bus.current[i*W +: W]),
            .thresh_i  (thresh_q),
            .mode_i    (mode_q),
            .spike_o   (bus.spike[i]),
            .state_o   (bus.state_out[i*W +: W])
        );
    end

endmodule
